// File: rtl/video_pkg.sv
// video_pkg: shared display/frame-buffer geometry and types
package video_pkg;
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int FRAME_PIXELS = 76800;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  typedef logic [23:0] pixel_t;
  typedef logic [16:0] fb_addr_t;
  typedef enum logic {WAIT_FRAME, SCAN} scan_state_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: fixed-depth shift register with async active-low clear to INIT
module sync_delay_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= INIT;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: 2x-upscaled frame buffer read with sync/blank realigned to returned pixels
module frame_scan_reader
  import video_pkg::pixel_t, video_pkg::fb_addr_t, video_pkg::scan_state_t,
         video_pkg::WAIT_FRAME, video_pkg::SCAN;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int READ_LATENCY = 2,
  parameter pixel_t BORDER_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output fb_addr_t    read_addr,
  input  pixel_t      buf_pixel,
  output pixel_t      pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_start
);
  localparam int L = READ_LATENCY + 2;
  localparam logic [10:0] W_COLS = 11'(FRAME_W);
  localparam logic [10:0] H_LAST = 11'(video_pkg::H_TOTAL - 1);
  localparam logic [9:0] H_ROWS = 10'(FRAME_H);
  localparam logic [9:0] ROW_LAST = 10'(FRAME_H - 1);
  localparam logic [9:0] SUB = 10'((1 << SCALE_SHIFT) - 1);
  localparam fb_addr_t W_STEP = 17'(FRAME_W);
  scan_state_t state, state_nx;
  fb_addr_t line_base, base_cur, addr_nx;
  logic [10:0] col;
  logic [9:0] row;
  logic origin, scan_now, valid, img_q;
  logic [4:0] dq;
  pixel_t pix_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= WAIT_FRAME;
    else state <= state_nx;
  always_comb begin
    origin = hcount == '0 && vcount == '0;
    state_nx = (state == WAIT_FRAME && origin) ? SCAN : state;
    scan_now = state_nx == SCAN;
    col = hcount >> SCALE_SHIFT;
    row = vcount >> SCALE_SHIFT;
    valid = scan_now && col < W_COLS && row < H_ROWS && !blank_in;
    base_cur = vcount == '0 ? '0 : line_base;
    addr_nx = valid ? base_cur + fb_addr_t'(col) : '0;
  end
  // line_base steps once per stored row; it stops at the last row so it never passes 76480
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      line_base <= '0;
      read_addr <= '0;
      pix_q <= BORDER_COLOR;
    end else begin
      line_base <= (hcount == H_LAST && (vcount & SUB) == SUB && row < ROW_LAST) ? base_cur + W_STEP : base_cur;
      read_addr <= addr_nx;
      pix_q <= buf_pixel;
    end
  sync_delay_line #(.WIDTH(5), .DEPTH(L), .INIT(5'b00100)) u_dly (
    .clk(clk),
    .reset(reset),
    .d({hsync_in, vsync_in, blank_in, valid, scan_now && origin}),
    .q(dq)
  );
  assign {hsync_out, vsync_out, blank_out, img_q, frame_start} = dq;
  assign pixel_out = img_q ? pix_q : BORDER_COLOR;
endmodule

// File: tb/tb_frame_scan_reader.sv
// tb_frame_scan_reader: reference-model and table checks of the upscaling frame reader
module tb_frame_scan_reader;
  import video_pkg::*;
  logic clk = 0;
  logic reset;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic hsync_in, vsync_in, blank_in;
  fb_addr_t read_addr, b1;
  pixel_t buf_pixel, pixel_out;
  logic hsync_out, vsync_out, blank_out, frame_start;
  typedef struct {int h; int v; int addr;} vec_t;
  typedef struct {int pix; bit hs; bit vs; bit bl; bit fs;} out_t;
  out_t pipe[$];
  vec_t tbl[14];
  bit hit[14];
  bit scanning;
  int checks, errors, fs_seen, hits;

  frame_scan_reader dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .read_addr(read_addr), .buf_pixel(buf_pixel), .pixel_out(pixel_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // buffer model: two-cycle read, stored pixel equals its address
  always_ff @(posedge clk) begin
    b1 <= read_addr;
    buf_pixel <= {7'b0, b1};
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, hcount, vcount, got, exp);
    end
  endtask

  task automatic rst_checks();
    chk("rst_read_addr", read_addr, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_hsync_out", hsync_out, 0);
    chk("rst_vsync_out", vsync_out, 0);
    chk("rst_blank_out", blank_out, 1);
    chk("rst_frame_start", frame_start, 0);
  endtask

  task automatic model_reset();
    out_t r;
    r = '{pix: 0, hs: 0, vs: 0, bl: 1, fs: 0};
    scanning = 0;
    pipe.delete();
    repeat (3) pipe.push_back(r);
  endtask

  task automatic set_in(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    hsync_in = !(h >= 656 && h < 752);
    vsync_in = !(v >= 490 && v < 492);
    blank_in = h >= 640 || v >= 480;
  endtask

  task automatic step(input int h, input int v);
    out_t e, o;
    bit img, sc;
    int a;
    set_in(h, v);
    img = h < 640 && v < 480;
    sc = scanning || (h == 0 && v == 0);
    a = (sc && img) ? (v / 2) * 320 + h / 2 : 0;
    e = '{pix: a, hs: hsync_in, vs: vsync_in, bl: blank_in, fs: sc && h == 0 && v == 0};
    scanning = sc;
    pipe.push_back(e);
    @(posedge clk);
    #1;
    chk("read_addr", read_addr, a);
    o = pipe.pop_front();
    chk("pixel_out", pixel_out, o.pix);
    chk("hsync_out", hsync_out, o.hs);
    chk("vsync_out", vsync_out, o.vs);
    chk("blank_out", blank_out, o.bl);
    chk("frame_start", frame_start, o.fs);
    if (frame_start) fs_seen++;
    if (sc)
      for (int i = 0; i < 14; i++)
        if (tbl[i].h == h && tbl[i].v == v) begin
          hit[i] = 1;
          chk("tbl_addr", read_addr, tbl[i].addr);
        end
  endtask

  task automatic mid_reset();
    reset = 0;
    #1;
    rst_checks();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  task automatic line(input int v, input int from, input bit rst_at);
    int hl[$];
    int r;
    r = $urandom_range(212, 620);
    for (int h = 0; h < 12; h++) hl.push_back(h);
    hl.push_back(200);
    for (int k = 0; k < 4; k++) hl.push_back(r + k);
    for (int h = 636; h < 644; h++) hl.push_back(h);
    hl.push_back(655); hl.push_back(656); hl.push_back(751); hl.push_back(752);
    hl.push_back(797); hl.push_back(798); hl.push_back(799);
    foreach (hl[k])
      if (hl[k] >= from) begin
        step(hl[k], v);
        if (rst_at && hl[k] == 200) mid_reset();
      end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0};       tbl[1] = '{1, 0, 0};
    tbl[2] = '{2, 0, 1};       tbl[3] = '{3, 0, 1};
    tbl[4] = '{639, 479, 76799}; tbl[5] = '{640, 0, 0};
    tbl[6] = '{0, 1, 0};       tbl[7] = '{0, 2, 320};
    tbl[8] = '{10, 5, 645};    tbl[9] = '{0, 479, 76480};
    tbl[10] = '{639, 0, 319};  tbl[11] = '{200, 300, 48100};
    tbl[12] = '{797, 524, 0};  tbl[13] = '{7, 480, 0};
    reset = 0;
    set_in(300, 100);
    #100;
    rst_checks();
    @(negedge clk);
    reset = 1;
    model_reset();
    line(100, 300, 0);
    line(101, 0, 0);
    line(524, 797, 0);
    for (int v = 0; v < 525; v++) line(v, 0, 0);
    for (int v = 0; v <= 300; v++) line(v, 0, v == 300);
    line(524, 797, 0);
    for (int v = 0; v < 525; v++) line(v, 0, 0);
    chk("frame_start_count", fs_seen, 3);
    hits = 0;
    foreach (hit[i]) hits += int'(hit[i]);
    chk("tbl_hits", hits, 14);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
